// File: rtl/instr_sequencer.sv
// Instruction fetch/decode sequencer driving reg_file_alu from a small program memory.
// Optional macro INSTR_SEQ_BRANCH_EN enables BEQZ/JMP; when it is undefined they decode as NOPs.
module instr_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [25:0]       prog_data,
  input  logic              Zero,
  output logic [3:0]        RA1,
  output logic [3:0]        RA2,
  output logic [3:0]        WA,
  output logic [7:0]        immediate,
  output logic              write_enable,
  output logic              ALUSrc,
  output logic [1:0]        ALUControl,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_BEQZ = 2'd1;
  localparam logic [1:0] CLS_JMP  = 2'd2;
  localparam logic [1:0] CLS_HALT = 2'd3;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [25:0]       prog_mem [2**ADDR_W];
  logic [25:0]       instr;
  logic [1:0]        cls;
  logic              run;

  assign run    = (state_reg == RUN);
  assign instr  = prog_mem[pc_reg];
  assign cls    = instr[25:24];
  assign pc_inc = pc_reg + ADDR_W'(1);

  // Loading is locked out while the program executes; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && prog_we && !run) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

`ifdef INSTR_SEQ_BRANCH_EN
  always_comb begin
    pc_next = pc_inc;
    case (cls)
      CLS_BEQZ: if (Zero) pc_next = instr[ADDR_W-1:0];
      CLS_JMP:  pc_next = instr[ADDR_W-1:0];
      default:  ;
    endcase
  end
`else
  logic unused_zero;
  assign unused_zero = Zero;
  assign pc_next     = pc_inc;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, HALTED: begin
          if (start) begin
            state_reg <= RUN;
            pc_reg    <= '0;
          end
        end
        RUN: begin
          if (cls == CLS_HALT) begin
            state_reg <= HALTED;
          end else begin
            pc_reg <= pc_next;
          end
        end
        default: begin
          state_reg <= IDLE;
          pc_reg    <= '0;
        end
      endcase
    end
  end

  // Decode is a pure function of the fetched word; everything is quiet outside RUN.
  always_comb begin
    RA1          = '0;
    RA2          = '0;
    WA           = '0;
    immediate    = '0;
    write_enable = 1'b0;
    ALUSrc       = 1'b0;
    ALUControl   = '0;
    if (run) begin
      ALUControl   = instr[23:22];
      ALUSrc       = instr[21];
      write_enable = instr[20] && (cls == CLS_ALU);
      WA           = instr[19:16];
      RA1          = instr[15:12];
      RA2          = instr[11:8];
      immediate    = instr[7:0];
    end
  end

  assign pc     = pc_reg;
  assign busy   = run;
  assign halted = (state_reg == HALTED);

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch/decode sequencer that sits directly upstream of `reg_file_alu` and drives all of its control inputs (RA1, RA2, WA, immediate, write_enable, ALUSrc, ALUControl) from a small program memory. It holds a program counter, issues one instruction per clock, and consumes the ALU's `Zero` flag to resolve conditional branches. Together with `reg_file_alu` it forms the single-cycle datapath.

## Interface
- `ADDR_W`, 5: program-memory address width; depth = 2**ADDR_W instructions.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; IDLE/HALTED -> RUN with PC=0.
- `prog_we` in 1: program-memory write strobe; honoured only outside RUN.
- `prog_addr` in ADDR_W: program-memory write address.
- `prog_data` in 26: instruction word to write.
- `Zero` in 1: zero flag from `reg_file_alu`, same cycle.
- `RA1`, `RA2`, `WA` out 4: register addresses to `reg_file_alu`.
- `immediate` out 8: immediate operand.
- `write_enable` out 1: register-file write enable.
- `ALUSrc` out 1: 1 selects immediate as ALU operand B.
- `ALUControl` out 2: ALU operation.
- `pc` out ADDR_W: current program counter.
- `busy` out 1: high in RUN.
- `halted` out 1: high in HALTED.

## Operation
- Instruction word [25:0]: [25:24] class, [23:22] ALUControl, [21] ALUSrc, [20] we, [19:16] WA, [15:12] RA1, [11:8] RA2, [7:0] immediate.
- Classes: 00 ALU, 01 BEQZ, 10 JMP, 11 HALT.
- Program memory: 2**ADDR_W x 26 register array, uninitialised after reset.
  - Asynchronous read at `pc`; synchronous write at `prog_addr` when `prog_we` && state != RUN.
  - Writes during RUN are dropped.
- FSM states: IDLE, RUN, HALTED. Reset -> IDLE, pc=0.
  - IDLE: `start` -> RUN, pc=0.
  - RUN: the class of the fetched word drives next state/pc.
    - ALU: pc <= pc+1, wrapping from 2**ADDR_W-1 to 0.
    - BEQZ: pc <= immediate[ADDR_W-1:0] if `Zero`, else pc+1.
    - JMP: pc <= immediate[ADDR_W-1:0].
    - HALT: -> HALTED, pc held.
  - HALTED: `start` -> RUN, pc=0.
  - `start` while in RUN is ignored.
- Decode outputs are valid only in RUN.
  - RA1, RA2, WA, immediate, ALUSrc, ALUControl come from the fetched fields.
  - write_enable = we && class==ALU; forced 0 for BEQZ, JMP and HALT.
  - BEQZ still drives RA1/RA2/ALUControl so the ALU produces `Zero` for the compare.
- Outside RUN, all decode outputs are 0.
- `busy` = (state==RUN); `halted` = (state==HALTED).

## Timing
- Reset values: pc=0, state IDLE, busy=0, halted=0, all decode outputs 0.
- Decode outputs are combinational from pc and state.
- Branch resolution is zero-latency: `Zero` is sampled in the same cycle as the BEQZ word, with no bubble.
- Throughput: one instruction retired per clock in RUN.
- `start` sampled at edge N: first instruction (address 0) presented in cycle N+1.
- HALT at edge N: HALTED from cycle N+1; write_enable is 0 during the HALT cycle itself.
- `RST` has priority over `start` and `prog_we`. Program memory contents are not cleared by reset.
- `RST` mid-RUN: next cycle is IDLE, pc=0, outputs 0.
- Simultaneous `start` and `prog_we` in IDLE: the write completes and the FSM enters RUN.
- A word written at address 0 in that same cycle is the first instruction fetched.

## Configuration
- `INSTR_SEQ_BRANCH_EN` defined: BEQZ and JMP behave as specified above.
- Not defined: classes 01 and 10 decode as NOPs.
  - pc <= pc+1 and write_enable = 0.
  - `Zero` is unused.
  - All other behaviour is unchanged.

## Test plan
- Reset/idle: assert RST 2 cycles, then hold `start`=0 for 3 cycles -> pc=0, busy=0, halted=0, every decode output 0 throughout.
- Straight-line ALU: load addr0 = ALU, ALUControl=00, ALUSrc=1, we=1, WA=1, RA1=0, imm=5; addr1 = HALT. Pulse `start`.
  - Cycle 1: WA=1, immediate=5, write_enable=1, pc=0.
  - Cycle 2: write_enable=0, pc=1.
  - Cycle 3: halted=1.
- BEQZ: addr0 = BEQZ, RA1=RA2=3, ALUControl=01, imm=6; addr6 = HALT; drive `Zero`=1.
  - Next pc=6, then HALTED.
  - Repeat with `Zero`=0 -> pc=1.
- JMP and wrap (ADDR_W=5):
  - addr0 = JMP imm=31, addr31 = ALU -> pc sequence 0, 31, 0.
  - write_enable=0 during the JMP cycle.
- Load guard and reset mid-run: start a JMP-to-self loop at addr0, then issue prog_we to addr0 with HALT during RUN.
  - The loop continues, because the write is dropped.
  - Assert RST -> IDLE, pc=0 next cycle.
  - Rewrite addr0 with HALT in IDLE, pulse `start` -> HALTED after one cycle.
- Macro off: build without `INSTR_SEQ_BRANCH_EN` and run the BEQZ program with `Zero`=1 -> pc=1 after the branch word, write_enable=0.
